// File: rtl/alarm_setter.sv
// Alarm time editor: IDLE -> SET_HOUR -> SET_MIN -> commit, with a registered 6-digit display.
// Define ALARM_ARM_EN to let pulsed_up in IDLE toggle alarm_armed; otherwise the alarm is always armed.
module alarm_setter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] currentMode,
    input  logic       real_quarter,
    input  logic       pulsed_set,
    input  logic       pulsed_up,
    input  logic       pulsed_down,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic       alarm_armed,
    output logic       commit,
    output logic [3:0] bch0,
    output logic [3:0] bch1,
    output logic [3:0] bch2,
    output logic [3:0] bch3,
    output logic [3:0] bch4,
    output logic [3:0] bch5,
    output logic       inSetState
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    localparam logic [3:0] BLANK = 4'd10;

    state_t     state_q, state_d;
    logic [4:0] edit_h_q, edit_h_d;
    logic [5:0] edit_m_q, edit_m_d;
    logic [4:0] alarm_h_q, alarm_h_d;
    logic [5:0] alarm_m_q, alarm_m_d;
    logic       commit_q, commit_d;
    logic [3:0] bch_q [6];
    logic [3:0] bch_d [6];

    function automatic logic [3:0] tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] units(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

    logic active, inc, dec;
    assign active = (currentMode == 2'd1);
    // Simultaneous up and down cancel out
    assign inc    = pulsed_up & ~pulsed_down;
    assign dec    = pulsed_down & ~pulsed_up;

    always_comb begin
        state_d   = state_q;
        edit_h_d  = edit_h_q;
        edit_m_d  = edit_m_q;
        alarm_h_d = alarm_h_q;
        alarm_m_d = alarm_m_q;
        commit_d  = 1'b0;
        if (!active) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pulsed_set) begin
                        state_d  = SET_HOUR;
                        edit_h_d = alarm_h_q;
                        edit_m_d = alarm_m_q;
                    end
                end
                SET_HOUR: begin
                    if (pulsed_set) begin
                        state_d = SET_MIN;
                    end else if (inc) begin
                        edit_h_d = (edit_h_q == 5'd23) ? 5'd0 : edit_h_q + 5'd1;
                    end else if (dec) begin
                        edit_h_d = (edit_h_q == 5'd0) ? 5'd23 : edit_h_q - 5'd1;
                    end
                end
                SET_MIN: begin
                    if (pulsed_set) begin
                        state_d   = IDLE;
                        alarm_h_d = edit_h_q;
                        alarm_m_d = edit_m_q;
                        commit_d  = 1'b1;
                    end else if (inc) begin
                        edit_m_d = (edit_m_q == 6'd59) ? 6'd0 : edit_m_q + 6'd1;
                    end else if (dec) begin
                        edit_m_d = (edit_m_q == 6'd0) ? 6'd59 : edit_m_q - 6'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Display follows the current (pre-edge) state, so it lags state/value changes by one cycle
    logic [4:0] disp_h;
    logic [5:0] disp_m;
    logic       blank_h, blank_m;
    always_comb begin
        disp_h  = (state_q == IDLE) ? alarm_h_q : edit_h_q;
        disp_m  = (state_q == IDLE) ? alarm_m_q : edit_m_q;
        blank_h = (state_q == SET_HOUR) && !real_quarter;
        blank_m = (state_q == SET_MIN) && !real_quarter;
        bch_d[0] = blank_h ? BLANK : tens({1'b0, disp_h});
        bch_d[1] = blank_h ? BLANK : units({1'b0, disp_h});
        bch_d[2] = blank_m ? BLANK : tens(disp_m);
        bch_d[3] = blank_m ? BLANK : units(disp_m);
        bch_d[4] = 4'd0;
        bch_d[5] = 4'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            edit_h_q  <= '0;
            edit_m_q  <= '0;
            alarm_h_q <= '0;
            alarm_m_q <= '0;
            commit_q  <= 1'b0;
            for (int i = 0; i < 6; i++) bch_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            edit_h_q  <= edit_h_d;
            edit_m_q  <= edit_m_d;
            alarm_h_q <= alarm_h_d;
            alarm_m_q <= alarm_m_d;
            commit_q  <= commit_d;
            for (int i = 0; i < 6; i++) bch_q[i] <= bch_d[i];
        end
    end

`ifdef ALARM_ARM_EN
    logic armed_q, armed_d;
    always_comb begin
        armed_d = armed_q;
        if (active && state_q == IDLE && !pulsed_set && pulsed_up)
            armed_d = ~armed_q;
    end
    always_ff @(posedge clk) begin
        if (reset) armed_q <= 1'b0;
        else       armed_q <= armed_d;
    end
    assign alarm_armed = armed_q;
`else
    assign alarm_armed = 1'b1;
`endif

    assign alarm_hours   = alarm_h_q;
    assign alarm_minutes = alarm_m_q;
    assign commit        = commit_q;
    assign inSetState    = (state_q != IDLE);
    assign bch0 = bch_q[0];
    assign bch1 = bch_q[1];
    assign bch2 = bch_q[2];
    assign bch3 = bch_q[3];
    assign bch4 = bch_q[4];
    assign bch5 = bch_q[5];
endmodule

// File: tb/tb_alarm_setter.sv
// Self-checking bench for alarm_setter: directed scenarios plus random stimulus against a behavioural model.
module tb_alarm_setter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] currentMode = 2'd1;
    logic       real_quarter = 1'b1;
    logic       pulsed_set = 1'b0, pulsed_up = 1'b0, pulsed_down = 1'b0;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       alarm_armed, commit, inSetState;
    logic [3:0] bch0, bch1, bch2, bch3, bch4, bch5;

    int checks = 0;
    int errors = 0;

    alarm_setter dut (
        .clk(clk), .reset(reset), .currentMode(currentMode), .real_quarter(real_quarter),
        .pulsed_set(pulsed_set), .pulsed_up(pulsed_up), .pulsed_down(pulsed_down),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .alarm_armed(alarm_armed),
        .commit(commit), .bch0(bch0), .bch1(bch1), .bch2(bch2), .bch3(bch3), .bch4(bch4),
        .bch5(bch5), .inSetState(inSetState)
    );

    always #5 clk = ~clk;

`ifdef ALARM_ARM_EN
    localparam bit ARM_EN = 1'b1;
`else
    localparam bit ARM_EN = 1'b0;
`endif

    // Behavioural model: mode 0 = idle, 1 = editing hour, 2 = editing minute
    int m_mode = 0, m_eh = 0, m_em = 0, m_ah = 0, m_am = 0;
    int m_commit = 0, m_armed = 0;
    int m_disp [6];

    function automatic logic [37:0] dut_vec();
        return {alarm_hours, alarm_minutes, alarm_armed, commit, inSetState,
                bch0, bch1, bch2, bch3, bch4, bch5};
    endfunction

    function automatic logic [37:0] model_vec();
        return {5'(m_ah), 6'(m_am), ARM_EN ? 1'(m_armed) : 1'b1, 1'(m_commit), m_mode != 0,
                4'(m_disp[0]), 4'(m_disp[1]), 4'(m_disp[2]), 4'(m_disp[3]),
                4'(m_disp[4]), 4'(m_disp[5])};
    endfunction

    // Drive one cycle of inputs, advance the model, return #1 after the clock edge
    task automatic step(input bit s, input bit u, input bit d, input int md, input bit rq, input bit r);
        int h, mi;
        @(negedge clk);
        pulsed_set = s; pulsed_up = u; pulsed_down = d;
        currentMode = 2'(md); real_quarter = rq; reset = r;
        @(posedge clk);
        #1;
        if (r) begin
            m_mode = 0; m_eh = 0; m_em = 0; m_ah = 0; m_am = 0; m_commit = 0; m_armed = 0;
            foreach (m_disp[i]) m_disp[i] = 0;
        end else begin
            h  = (m_mode == 0) ? m_ah : m_eh;
            mi = (m_mode == 0) ? m_am : m_em;
            m_disp[0] = (m_mode == 1 && !rq) ? 10 : h / 10;
            m_disp[1] = (m_mode == 1 && !rq) ? 10 : h % 10;
            m_disp[2] = (m_mode == 2 && !rq) ? 10 : mi / 10;
            m_disp[3] = (m_mode == 2 && !rq) ? 10 : mi % 10;
            m_disp[4] = 0; m_disp[5] = 0;
            m_commit = 0;
            if (md != 1) m_mode = 0;
            else if (m_mode == 0) begin
                if (s) begin m_mode = 1; m_eh = m_ah; m_em = m_am; end
                else if (u) m_armed = !m_armed;
            end else if (m_mode == 1) begin
                if (s) m_mode = 2;
                else if (u && !d) m_eh = (m_eh + 1) % 24;
                else if (d && !u) m_eh = (m_eh + 23) % 24;
            end else begin
                if (s) begin m_mode = 0; m_ah = m_eh; m_am = m_em; m_commit = 1; end
                else if (u && !d) m_em = (m_em + 1) % 60;
                else if (d && !u) m_em = (m_em + 59) % 60;
            end
        end
        pulsed_set = 0; pulsed_up = 0; pulsed_down = 0;
    endtask

    task automatic test_reset();
        step(1, 1, 0, 1, 1, 1);
        checks++;
        if (dut_vec() !== {5'd0, 6'd0, !ARM_EN, 1'b0, 1'b0, 24'd0}) begin
            errors++; $display("FAIL reset_state: got %h expected %h", dut_vec(), {5'd0, 6'd0, !ARM_EN, 1'b0, 1'b0, 24'd0});
        end
    endtask

    task automatic test_commit_sequence();
        int pulses = 0;
        step(0, 0, 0, 1, 1, 1);
        step(1, 0, 0, 1, 1, 0);
        checks++;
        if (inSetState !== 1'b1) begin errors++; $display("FAIL enter_set: inSetState=%b expected 1", inSetState); end
        repeat (3) step(0, 1, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        repeat (2) step(0, 0, 1, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        pulses += commit;
        checks++;
        if (alarm_hours !== 5'd3 || alarm_minutes !== 6'd58 || commit !== 1'b1) begin
            errors++; $display("FAIL commit_seq: got %0d:%0d commit=%b expected 3:58 commit=1", alarm_hours, alarm_minutes, commit);
        end
        repeat (3) begin step(0, 0, 0, 1, 1, 0); pulses += commit; end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL commit_width: commit high %0d cycles expected 1", pulses); end
        checks++;
        if ({bch0, bch1, bch2, bch3} !== {4'd0, 4'd3, 4'd5, 4'd8}) begin
            errors++; $display("FAIL commit_display: got %h expected 0358", {bch0, bch1, bch2, bch3});
        end
    endtask

    task automatic test_hour_wrap();
        step(0, 0, 0, 1, 1, 1);
        step(1, 0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        checks++;
        if (bch0 !== 4'd2 || bch1 !== 4'd3) begin
            errors++; $display("FAIL hour_wrap: bch0=%0d bch1=%0d expected 2 3", bch0, bch1);
        end
    endtask

    task automatic test_min_wrap_blink();
        step(0, 0, 0, 1, 1, 1);
        step(1, 0, 0, 1, 1, 0);
        step(0, 1, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        checks++;
        if ({bch2, bch3} !== {4'd5, 4'd9}) begin errors++; $display("FAIL min_at_59: got %h expected 59", {bch2, bch3}); end
        step(0, 1, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if ({bch0, bch1, bch2, bch3} !== {4'd0, 4'd1, 4'd10, 4'd10}) begin
            errors++; $display("FAIL min_blank: got %h expected 01aa", {bch0, bch1, bch2, bch3});
        end
        step(0, 0, 0, 1, 1, 0);
        checks++;
        if ({bch2, bch3} !== {4'd0, 4'd0}) begin errors++; $display("FAIL min_wrap: got %h expected 00", {bch2, bch3}); end
    endtask

    task automatic test_abort();
        int pulses = 0;
        step(0, 0, 0, 1, 1, 1);
        step(1, 0, 0, 1, 1, 0);
        repeat (7) step(0, 1, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        repeat (30) step(0, 1, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        repeat (2) begin step(0, 1, 0, 1, 1, 0); pulses += commit; end
        step(0, 0, 0, 0, 1, 0); pulses += commit;
        checks++;
        if (inSetState !== 1'b0) begin errors++; $display("FAIL abort_idle: inSetState=%b expected 0", inSetState); end
        step(1, 1, 1, 0, 1, 0); pulses += commit;
        checks++;
        if (pulses != 0 || alarm_hours !== 5'd7 || alarm_minutes !== 6'd30 || inSetState !== 1'b0) begin
            errors++; $display("FAIL abort_keep: got %0d:%0d commits=%0d set=%b expected 7:30 commits=0 set=0", alarm_hours, alarm_minutes, pulses, inSetState);
        end
        checks++;
        if ({bch0, bch1, bch2, bch3, bch4, bch5} !== {4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0}) begin
            errors++; $display("FAIL abort_display: got %h expected 073000", {bch0, bch1, bch2, bch3, bch4, bch5});
        end
    endtask

    task automatic test_updown_reset();
        int pulses = 0;
        step(0, 0, 0, 1, 1, 1);
        step(1, 0, 0, 1, 1, 0);
        repeat (5) step(0, 1, 0, 1, 1, 0);
        step(0, 1, 1, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        checks++;
        if ({bch0, bch1} !== {4'd0, 4'd5}) begin errors++; $display("FAIL up_down_same: got %h expected 05", {bch0, bch1}); end
        step(1, 0, 0, 1, 1, 0);
        step(1, 1, 0, 1, 1, 1);
        checks++;
        if (dut_vec() !== {5'd0, 6'd0, !ARM_EN, 1'b0, 1'b0, 24'd0}) begin
            errors++; $display("FAIL reset_mid_edit: got %h expected %h", dut_vec(), {5'd0, 6'd0, !ARM_EN, 1'b0, 1'b0, 24'd0});
        end
        repeat (3) begin step(0, 0, 0, 1, 1, 0); pulses += commit; end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL reset_no_commit: commit pulses=%0d expected 0", pulses); end
    endtask

    task automatic test_arm();
        step(0, 0, 0, 1, 1, 1);
        step(0, 1, 0, 1, 1, 0);
        checks++;
        if (alarm_armed !== 1'b1) begin errors++; $display("FAIL arm_first: got %b expected 1", alarm_armed); end
        step(0, 0, 1, 1, 1, 0);
        checks++;
        if (alarm_armed !== 1'b1) begin errors++; $display("FAIL arm_down_noop: got %b expected 1", alarm_armed); end
        step(0, 1, 0, 1, 1, 0);
        checks++;
        if (alarm_armed !== !ARM_EN) begin errors++; $display("FAIL arm_second: got %b expected %b", alarm_armed, !ARM_EN); end
    endtask

    task automatic test_random();
        int bad = 0;
        step(0, 0, 0, 1, 1, 1);
        for (int n = 0; n < 2000; n++) begin
            int md;
            md = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : 1;
            step($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 md, $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                if (bad < 10) $display("FAIL random_cycle %0d: got %h expected %h", n, dut_vec(), model_vec());
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_commit_sequence();
        test_hour_wrap();
        test_min_wrap_blink();
        test_abort();
        test_updown_reset();
        test_arm();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
